// File: rtl/adder_bist_controller_pkg.sv
// Shared encodings for the carry-save adder BIST controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package adder_bist_pkg;

    // Sweep patterns. Encoding 3 is reserved and runs as the diagonal sweep.
    typedef enum logic [1:0] {
        MODE_DIAG     = 2'd0,
        MODE_FULL     = 2'd1,
        MODE_FULL_CIN = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_FULL;
            2'd2:    return MODE_FULL_CIN;
            default: return MODE_DIAG;
        endcase
    endfunction

endpackage

// File: rtl/adder_bist_controller_if.sv
// Operand/result bus between the BIST controller and the adder under test.
// Latency: none (wires only).
// Backpressure: none; the adder must take one operand set per clock.
//   dut_in1/dut_in2/dut_cin : operands, driven by the controller (master)
//   dut_sum                 : adder result, driven by the adder (slave)
interface adder_bist_controller_if #(
    parameter int IN_DATAWIDTH  = 4,
    parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1
);
    logic [IN_DATAWIDTH-1:0]  dut_in1;
    logic [IN_DATAWIDTH-1:0]  dut_in2;
    logic                     dut_cin;
    logic [OUT_DATAWIDTH-1:0] dut_sum;

    modport master (output dut_in1, output dut_in2, output dut_cin, input dut_sum);
    modport slave  (input dut_in1, input dut_in2, input dut_cin, output dut_sum);
endinterface

// File: rtl/adder_bist_controller_delay_line.sv
// DEPTH-stage shift register aligning issued vectors with the adder's result.
// Latency: DEPTH clocks from d to q.
// Backpressure: none; shifts every clock.
//   clk, rst_n : clock, async active-low reset (all stages clear to 0)
//   d / q      : WIDTH-bit input / output of the delay line
module bist_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/adder_bist_controller.sv
// On-chip BIST for the FIR carry-save adder: sweeps operands, checks sums, logs first failure.
// Latency: done rises N+DUT_LATENCY+2 clocks after the accepted start (N = vectors in sweep).
// Backpressure: none; one vector per clock, start is ignored while busy.
//   clk, rst_n        : clock, async active-low reset
//   start, mode       : sweep request pulse and pattern select (latched on accept)
//   adder             : operand/result bus to the adder under test (master side)
//   busy, done, pass  : sweep status; pass is meaningful while done is high
//   err_count         : saturating mismatch count for the current/last sweep
//   first_err_*       : operands and observed sum of the first failing vector
module adder_bist_controller
    import adder_bist_pkg::*;
#(
    parameter int IN_DATAWIDTH  = 4,
    parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
    parameter int DUT_LATENCY   = 0,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    adder_bist_controller_if.master  adder,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [IN_DATAWIDTH-1:0]  first_err_in1,
    output logic [IN_DATAWIDTH-1:0]  first_err_in2,
    output logic                     first_err_cin,
    output logic [OUT_DATAWIDTH-1:0] first_err_sum
);

    localparam int W       = IN_DATAWIDTH;
    localparam int CNT_W   = 2 * W + 1;
    localparam int DEPTH   = DUT_LATENCY + 1;
    localparam int DRAIN_W = (DUT_LATENCY > 0) ? $clog2(DUT_LATENCY + 1) : 1;

    typedef struct packed {
        logic                     vld;
        logic [W-1:0]             in1;
        logic [W-1:0]             in2;
        logic                     cin;
        logic [OUT_DATAWIDTH-1:0] gold;
    } vec_t;

    state_e             state;
    mode_e              mode_q;
    logic [CNT_W-1:0]   cnt;
    logic               last_issued;
    logic [DRAIN_W-1:0] drain_cnt;

    logic [W-1:0] v_in1;
    logic [W-1:0] v_in2;
    logic         v_cin;
    logic         v_last;
    logic         issue;
    logic         mismatch;
    vec_t         dl_in;
    vec_t         dl_out;

    // Map the counter onto operands for the latched pattern and flag the final vector.
    // The counter is only as wide as the largest sweep, so "last" is detected by value
    // rather than by comparing against N (which would not fit for the cin sweep).
    always_comb begin
        v_in1  = '0;
        v_in2  = '0;
        v_cin  = 1'b0;
        v_last = 1'b0;
        case (mode_q)
            MODE_FULL: begin
                v_in2  = cnt[W-1:0];
                v_in1  = cnt[2*W-1:W];
                v_last = &cnt[2*W-1:0];
            end
            MODE_FULL_CIN: begin
                v_cin  = cnt[0];
                v_in2  = cnt[W:1];
                v_in1  = cnt[2*W:W+1];
                v_last = &cnt;
            end
            default: begin
                v_in1  = cnt[W-1:0];
                v_in2  = cnt[W-1:0];
                v_last = &cnt[W-1:0];
            end
        endcase
    end

    assign issue = (state == S_RUN) && !last_issued;

    always_comb begin
        dl_in      = '0;
        dl_in.vld  = issue;
        dl_in.in1  = v_in1;
        dl_in.in2  = v_in2;
        dl_in.cin  = v_cin;
        dl_in.gold = OUT_DATAWIDTH'(v_in1) + OUT_DATAWIDTH'(v_in2) + OUT_DATAWIDTH'(v_cin);
    end

    // Stage 0 loads on the same edge as the operand registers, so the output of stage
    // DUT_LATENCY lines up with the adder's sum for that vector.
    bist_delay_line #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(vec_t))
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dl_in),
        .q     (dl_out)
    );

    assign mismatch = dl_out.vld && (adder.dut_sum != dl_out.gold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mode_q        <= MODE_DIAG;
            cnt           <= '0;
            last_issued   <= 1'b0;
            drain_cnt     <= '0;
            adder.dut_in1 <= '0;
            adder.dut_in2 <= '0;
            adder.dut_cin <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_in1 <= '0;
            first_err_in2 <= '0;
            first_err_cin <= 1'b0;
            first_err_sum <= '0;
        end else begin
            // Compare runs in every state so in-flight vectors finish during DRAIN.
            if (mismatch) begin
                if (err_count != '1) begin
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                end
                if (err_count == '0) begin
                    first_err_in1 <= dl_out.in1;
                    first_err_in2 <= dl_out.in2;
                    first_err_cin <= dl_out.cin;
                    first_err_sum <= adder.dut_sum;
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state         <= S_RUN;
                        mode_q        <= decode_mode(mode);
                        cnt           <= '0;
                        last_issued   <= 1'b0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= '0;
                        first_err_in1 <= '0;
                        first_err_in2 <= '0;
                        first_err_cin <= 1'b0;
                        first_err_sum <= '0;
                    end
                end
                S_RUN: begin
                    if (!last_issued) begin
                        adder.dut_in1 <= v_in1;
                        adder.dut_in2 <= v_in2;
                        adder.dut_cin <= v_cin;
                        cnt           <= cnt + CNT_W'(1);
                        last_issued   <= v_last;
                    end else begin
                        // Final vector has had its cycle on the bus; park the bus at 0.
                        adder.dut_in1 <= '0;
                        adder.dut_in2 <= '0;
                        adder.dut_cin <= 1'b0;
                        drain_cnt     <= '0;
                        state         <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // By the last DRAIN edge every compare has already updated err_count.
                    if (drain_cnt == DRAIN_W'(DUT_LATENCY)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0);
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
